imem_arb: RTL and testbench

IMEM_ARB -- requirements
Module: imem_arb

---
 rtl/imem_pkg.sv | 13 +
 rtl/rr_arb2.sv | 29 ++
 rtl/imem_arb.sv | 133 +++++++++++++
 tb/tb_imem_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg -- shared definitions for the instruction-memory arbiter.
//   state_t    : response FSM encoding (IDLE / RESP)
//   WORD_BYTES : bytes per fetched instruction word
package imem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter with a single "last winner" flag.
//   clk, rst     : clock, asynchronous active-low reset
//   req_a, req_b : requests (a = loader, b = fetch)
//   gnt_a, gnt_b : one-hot-or-zero grants, combinational from requests
// On contention the requester that did not win last time is granted.
// The flag updates on every grant, contested or not.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_a;

  assign gnt_a = req_a && (!req_b || !last_a);
  assign gnt_b = req_b && (!req_a ||  last_a);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_a <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      last_a <= gnt_a;
    end
  end

endmodule

// File: rtl/imem_arb.sv
// imem_arb -- shares one byte-wide-write / word-read instruction memory
// between a fetch unit (word reads) and a loader (byte writes).
//   clk, rst                          : clock, asynchronous active-low reset
//   f_req/f_addr/f_gnt                : fetch request, granted combinationally
//   f_rvalid/f_rready/f_rdata/f_err   : fetch response, valid one cycle after grant
//   l_req/l_addr/l_wdata/l_gnt/l_err  : loader byte write, l_err pulses after a dropped write
//   l_lock                            : loader burst lock (only with IMEM_ARB_LOCK_EN)
//   mem_addr/mem_we/mem_wdata/mem_rdata : memory port, mem_rdata combinational at mem_addr
//   dbg_state                         : current response FSM state
// Handshake: a request is accepted in the cycle its gnt is 1; a response
// transfers in the cycle f_rvalid && f_rready, and f_rdata/f_err stay
// stable while f_rvalid is held without f_rready.
// Build option: define IMEM_ARB_LOCK_EN to enable the loader burst lock.
module imem_arb
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = 3200,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              f_rready,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [7:0]        l_wdata,
  output logic              l_gnt,
  output logic              l_err,
  input  logic              l_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata,
  output state_t            dbg_state
);

  localparam logic [ADDR_W-1:0] F_MAX = ADDR_W'(MEM_BYTES - WORD_BYTES);
  localparam logic [ADDR_W-1:0] L_END = ADDR_W'(MEM_BYTES);

  state_t state, state_nxt;
  logic   lock_blk;
  logic   same_word;
  logic   f_elig, l_elig;
  logic   f_bad, l_in;

`ifdef IMEM_ARB_LOCK_EN
  // Set by a locked loader grant, cleared the cycle after l_lock drops,
  // so fetch stays blocked through the cycle in which l_lock falls.
  logic lock_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 1'b0;
    end else if (!l_lock) begin
      lock_q <= 1'b0;
    end else if (l_gnt) begin
      lock_q <= 1'b1;
    end
  end

  assign lock_blk = lock_q;
`else
  logic unused_lock;
  assign unused_lock = l_lock;
  assign lock_blk    = 1'b0;
`endif

  // A pending write to the word being fetched always goes first, so the
  // fetch returns the updated word.
  assign same_word = l_req && (f_addr[ADDR_W-1:2] == l_addr[ADDR_W-1:2]);

  assign f_elig = rst && f_req && (state == IDLE) && !lock_blk && !same_word;
  assign l_elig = rst && l_req;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_a (l_elig),
    .req_b (f_elig),
    .gnt_a (l_gnt),
    .gnt_b (f_gnt)
  );

  assign f_bad = (f_addr[1:0] != 2'b00) || (f_addr > F_MAX);
  assign l_in  = (l_addr < L_END);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (l_gnt && l_in) begin
      mem_addr  = l_addr;
      mem_we    = 1'b1;
      mem_wdata = l_wdata;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (f_gnt)    state_nxt = RESP;
      RESP:    if (f_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      f_rdata <= '0;
      f_err   <= 1'b0;
      l_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      l_err <= l_gnt && !l_in;
      if (f_gnt) begin
        f_rdata <= f_bad ? 32'h0 : mem_rdata;
        f_err   <= f_bad;
      end
    end
  end

  assign f_rvalid  = (state == RESP);
  assign dbg_state = state;

endmodule

// File: tb/tb_imem_arb.sv
module tb_imem_arb;
  import imem_pkg::*;

  localparam int MEM = 3200;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_rready, l_req, l_lock;
  logic [31:0] f_addr, l_addr;
  logic [7:0]  l_wdata;
  logic        f_gnt, f_rvalid, f_err, l_gnt, l_err, mem_we;
  logic [31:0] f_rdata, mem_addr, mem_rdata;
  logic [7:0]  mem_wdata;
  state_t      dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  imem_arb #(.MEM_BYTES(MEM), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rready(f_rready), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_err(l_err), .l_lock(l_lock),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // memory model: byte i holds i[7:0] until overwritten
  logic [7:0]     wr_val [0:MEM-1];
  logic [MEM-1:0] wr_vld;
  logic [11:0]    ma;
  assign ma = mem_addr[11:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_vld <= '0;
    end else if (mem_we && mem_addr < 32'(MEM)) begin
      wr_vld[ma] <= 1'b1;
      wr_val[ma] <= mem_wdata;
    end
  end

  function automatic logic [7:0] byte_at(input logic [11:0] a);
    return wr_vld[a] ? wr_val[a] : a[7:0];
  endfunction

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 32'(MEM - 4))
      mem_rdata = {byte_at(ma + 12'd3), byte_at(ma + 12'd2), byte_at(ma + 12'd1), byte_at(ma)};
  end

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: fetch one word with f_rready=1, check grant and response
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e,
                          input string tag);
    @(negedge clk);
    f_req = 1'b1; f_addr = a; f_rready = 1'b1;
    #1;
    chk({tag, "_gnt"}, 32'(f_gnt), 32'd1);
    chk({tag, "_maddr"}, mem_addr, a);
    @(negedge clk);
    f_req = 1'b0;
    #1;
    chk({tag, "_rvalid"}, 32'(f_rvalid), 32'd1);
    chk({tag, "_rdata"}, f_rdata, exp_d);
    chk({tag, "_err"}, 32'(f_err), 32'(exp_e));
  endtask

  initial begin
    rst = 1'b0; f_req = 1'b1; f_addr = 32'h10; f_rready = 1'b1;
    l_req = 1'b1; l_addr = 32'h0; l_wdata = 8'h0; l_lock = 1'b0;

    // reset state, requests held
    @(negedge clk); #1;
    chk("rst_fgnt", 32'(f_gnt), 32'd0);
    chk("rst_lgnt", 32'(l_gnt), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_rdata", f_rdata, 32'd0);
    chk("rst_ferr", 32'(f_err), 32'd0);
    chk("rst_lerr", 32'(l_err), 32'd0);
    @(negedge clk);
    rst = 1'b1; f_req = 1'b0; l_req = 1'b0;

    // single fetch, then back to idle
    do_fetch(32'h10, 32'h13121110, 1'b0, "f10");
    @(negedge clk); #1;
    chk("f10_idle", 32'(f_rvalid), 32'd0);

    // contention: L, F, L (fetch blocked by RESP), F
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h20; l_req = 1'b1; l_addr = 32'h100; l_wdata = 8'h5A;
    #1;
    chk("rr0_lgnt", 32'(l_gnt), 32'd1);
    chk("rr0_fgnt", 32'(f_gnt), 32'd0);
    chk("rr0_we", 32'(mem_we), 32'd1);
    chk("rr0_maddr", mem_addr, 32'h100);
    @(negedge clk); #1;
    chk("rr1_fgnt", 32'(f_gnt), 32'd1);
    chk("rr1_lgnt", 32'(l_gnt), 32'd0);
    @(negedge clk);
    l_addr = 32'h101; l_wdata = 8'h6B;
    #1;
    chk("rr2_lgnt", 32'(l_gnt), 32'd1);
    chk("rr2_fgnt", 32'(f_gnt), 32'd0);
    chk("rr2_rdata", f_rdata, 32'h23222120);
    @(negedge clk); #1;
    chk("rr3_fgnt", 32'(f_gnt), 32'd1);
    chk("rr3_lgnt", 32'(l_gnt), 32'd0);
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0;
    #1;
    chk("rr4_rvalid", 32'(f_rvalid), 32'd1);

    // written bytes visible to fetch
    do_fetch(32'h100, 32'h03026B5A, 1'b0, "f100");

    // misaligned, out of range, last valid word
    do_fetch(32'h12, 32'h0, 1'b1, "f12");
    do_fetch(32'd3198, 32'h0, 1'b1, "f3198");
    do_fetch(32'd3196, 32'h7F7E7D7C, 1'b0, "f3196");

    // loader at last byte, then one past the end
    @(negedge clk);
    l_req = 1'b1; l_addr = 32'd3199; l_wdata = 8'h77;
    #1;
    chk("l3199_gnt", 32'(l_gnt), 32'd1);
    chk("l3199_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    l_addr = 32'd3200;
    #1;
    chk("l3200_gnt", 32'(l_gnt), 32'd1);
    chk("l3200_we", 32'(mem_we), 32'd0);
    chk("l3200_noerr_yet", 32'(l_err), 32'd0);
    @(negedge clk);
    l_req = 1'b0;
    #1;
    chk("l3200_err", 32'(l_err), 32'd1);
    @(negedge clk); #1;
    chk("l3200_err_end", 32'(l_err), 32'd0);

    // backpressure: response held, fetch not granted, loader still served
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h30; f_rready = 1'b0;
    #1;
    chk("bp_gnt", 32'(f_gnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      l_req = (i == 1); l_addr = 32'h200; l_wdata = 8'h11;
      #1;
      chk("bp_rvalid", 32'(f_rvalid), 32'd1);
      chk("bp_rdata", f_rdata, 32'h33323130);
      chk("bp_err", 32'(f_err), 32'd0);
      chk("bp_fgnt", 32'(f_gnt), 32'd0);
      chk("bp_lgnt", 32'(l_gnt), 32'(i == 1));
    end
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0; f_rready = 1'b1;
    #1;
    chk("bp_release", 32'(f_rvalid), 32'd1);

    // same-word collision: loader goes first although fetch is due
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h40; l_req = 1'b1; l_addr = 32'h41; l_wdata = 8'hEE;
    #1;
    chk("sw_lgnt", 32'(l_gnt), 32'd1);
    chk("sw_fgnt", 32'(f_gnt), 32'd0);
    @(negedge clk);
    l_req = 1'b0;
    #1;
    chk("sw_fgnt2", 32'(f_gnt), 32'd1);
    @(negedge clk);
    f_req = 1'b0;
    #1;
    chk("sw_rdata", f_rdata, 32'h4342EE40);

    // reset while a response is pending
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h50; f_rready = 1'b0;
    #1;
    chk("mr_gnt", 32'(f_gnt), 32'd1);
    @(negedge clk);
    f_req = 1'b0;
    #1;
    chk("mr_rvalid", 32'(f_rvalid), 32'd1);
    chk("mr_rdata", f_rdata, 32'h53525150);
    #2;
    rst = 1'b0; f_req = 1'b1;
    #1;
    chk("mr_rst_rvalid", 32'(f_rvalid), 32'd0);
    chk("mr_rst_rdata", f_rdata, 32'd0);
    chk("mr_rst_fgnt", 32'(f_gnt), 32'd0);
    @(negedge clk);
    rst = 1'b1; f_req = 1'b0; f_rready = 1'b1;
    #1;
    chk("mr_after0", 32'(f_rvalid), 32'd0);
    @(negedge clk); #1;
    chk("mr_after1", 32'(f_rvalid), 32'd0);

`ifdef IMEM_ARB_LOCK_EN
    // locked burst of 5 writes blocks fetch until the cycle after unlock
    f_req = 1'b1; f_addr = 32'h60; l_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      l_req = 1'b1; l_addr = 32'h300 + 32'(i); l_wdata = 8'(i);
      #1;
      chk("lk_fgnt", 32'(f_gnt), 32'd0);
      chk("lk_lgnt", 32'(l_gnt), 32'd1);
    end
    @(negedge clk);
    l_lock = 1'b0; l_req = 1'b0;
    #1;
    chk("lk_fall_fgnt", 32'(f_gnt), 32'd0);
    @(negedge clk); #1;
    chk("lk_resume_fgnt", 32'(f_gnt), 32'd1);
    @(negedge clk);
    f_req = 1'b0;
    #1;
    chk("lk_rdata", f_rdata, 32'h63626160);
`else
    // l_lock has no effect: round-robin continues
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h60; l_req = 1'b1; l_lock = 1'b1; l_addr = 32'h300;
    #1;
    chk("nl_lgnt", 32'(l_gnt), 32'd1);
    chk("nl_fgnt", 32'(f_gnt), 32'd0);
    @(negedge clk); #1;
    chk("nl_fgnt2", 32'(f_gnt), 32'd1);
    @(negedge clk);
    f_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
    #1;
    chk("nl_rdata", f_rdata, 32'h63626160);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
